// File: rtl/mc_defs.sv
// Shared definitions for the multicycle MIPS control unit: state and opcode
// encodings, datapath select encodings, and small opcode classifiers.
package mc_defs;

  localparam int OPCODE_W = 6;
  localparam int STATE_W  = 4;

  // Instruction phases. The encodings are visible on the State debug port.
  typedef enum logic [STATE_W-1:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_AL = 4'b0010,
    S_EXE_BR = 4'b0011,
    S_EXE_LS = 4'b0100,
    S_MEM    = 4'b0101,
    S_WB_AL  = 4'b0110,
    S_WB_LD  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  // ALU-class opcodes
  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPCODE_W-1:0] OP_SLT   = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b100111;
  // Memory, branch, jump, halt
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPCODE_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_OR   = 3'b010,
    ALU_AND  = 3'b011,
    ALU_SLL  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_XOR  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_SHAMT = 2'b00,
    EXT_ZIMM  = 2'b01,
    EXT_SIMM  = 2'b10
  } ext_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_RS     = 2'b10,
    PC_JUMP   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    DST_RA = 2'b00,
    DST_RT = 2'b01,
    DST_RD = 2'b10
  } reg_dst_e;

  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
      OP_ORI, OP_SLL, OP_SLT, OP_SLTIU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // ALU ops whose second operand is the extended immediate (and whose
  // destination is rt rather than rd)
  function automatic logic is_imm_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SLTIU);
  endfunction

  function automatic alu_op_e alu_op_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_OR, OP_ORI:  return ALU_OR;
      OP_AND:         return ALU_AND;
      OP_SLL:         return ALU_SLL;
      OP_SLT:         return ALU_SLT;
      OP_SLTIU:       return ALU_SLTU;
      default:        return ALU_ADD;
    endcase
  endfunction

  // The extend stage is steered by opcode alone, in every state.
  function automatic ext_sel_e ext_sel_of(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ORI:  return EXT_ZIMM;
      OP_SLL:  return EXT_SHAMT;
      default: return EXT_SIMM;
    endcase
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state logic for the multicycle control FSM.
module mc_next_state
  import mc_defs::*;
(
  input  state_e                state_i,
  input  logic [OPCODE_W-1:0]   opcode_i,
  output state_e                state_o
);

  // Phase sequencing; ID dispatches on instruction class, undefined opcodes halt.
  always_comb begin
    state_o = S_IF;
    case (state_i)
      S_IF: state_o = S_ID;
      S_ID: begin
        if ((opcode_i == OP_J) || (opcode_i == OP_JR) || (opcode_i == OP_JAL))
          state_o = S_IF;
        else if (is_alu_op(opcode_i))
          state_o = S_EXE_AL;
        else if ((opcode_i == OP_BEQ) || (opcode_i == OP_BLTZ))
          state_o = S_EXE_BR;
        else if ((opcode_i == OP_LW) || (opcode_i == OP_SW))
          state_o = S_EXE_LS;
        else
          state_o = S_HALT;
      end
      S_EXE_AL: state_o = S_WB_AL;
      S_EXE_BR: state_o = S_IF;
      S_EXE_LS: state_o = S_MEM;
      S_MEM:    state_o = (opcode_i == OP_LW) ? S_WB_LD : S_IF;
      S_WB_AL:  state_o = S_IF;
      S_WB_LD:  state_o = S_IF;
      S_HALT:   state_o = S_HALT;
      default:  state_o = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control unit: state register plus combinational decode of
// every datapath strobe and select from (State, Opcode, Zero, Sign).
//
//   state    | meaning
//   IF       | fetch: load IR from instruction memory
//   ID       | decode; jumps complete here
//   EXE_AL   | ALU operation for arithmetic/logic ops
//   EXE_BR   | compare for beq/bltz, PC update
//   EXE_LS   | address computation for lw/sw
//   MEM      | data memory access (sw completes here)
//   WB_AL    | write ALU result to register file
//   WB_LD    | write loaded data to register file
//   HALT     | stopped until reset
module mc_control_unit
  import mc_defs::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           CLK,
  input  logic           RST_n,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           Sign,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic [1:0]     ExtSel,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic           WrRegDSrc,
  output logic           DBDataSrc,
  output logic           mRD,
  output logic           mWR,
  output logic [1:0]     PCSrc,
  output logic [STW-1:0] State
);

  state_e   state_q;
  state_e   state_d;

  logic     pcwre_c;
  logic     irwre_c;
  logic     regwre_c;
  logic     mwr_c;
  logic     mrd_c;
  logic     insmem_c;
  logic     srca_c;
  logic     srcb_c;
  alu_op_e  aluop_c;
  ext_sel_e ext_c;
  reg_dst_e regdst_c;
  logic     wrsrc_c;
  logic     dbsrc_c;
  pc_src_e  pcsrc_c;

  mc_next_state u_next_state (
    .state_i  (state_q),
    .opcode_i (Opcode),
    .state_o  (state_d)
  );

  // State register; reset forces IF immediately, even mid-instruction.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Output decode. ALU selects are held through the state after EXE so the
  // datapath sees stable operands while writing back or accessing memory.
  always_comb begin
    pcwre_c  = 1'b0;
    irwre_c  = 1'b0;
    regwre_c = 1'b0;
    mwr_c    = 1'b0;
    mrd_c    = 1'b0;
    insmem_c = 1'b0;
    srca_c   = 1'b0;
    srcb_c   = 1'b0;
    aluop_c  = ALU_ADD;
    ext_c    = ext_sel_of(Opcode);
    regdst_c = DST_RA;
    wrsrc_c  = 1'b0;
    dbsrc_c  = 1'b0;
    pcsrc_c  = PC_SEQ;
    case (state_q)
      S_IF: begin
        irwre_c  = 1'b1;
        insmem_c = 1'b1;
      end
      S_ID: begin
        case (Opcode)
          OP_J: begin
            pcsrc_c = PC_JUMP;
            pcwre_c = 1'b1;
          end
          OP_JR: begin
            pcsrc_c = PC_RS;
            pcwre_c = 1'b1;
          end
          OP_JAL: begin
            pcsrc_c  = PC_JUMP;
            pcwre_c  = 1'b1;
            regwre_c = 1'b1;
            regdst_c = DST_RA;
            wrsrc_c  = 1'b0;
          end
          default: ;
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        aluop_c = alu_op_of(Opcode);
        srcb_c  = is_imm_op(Opcode);
        srca_c  = (Opcode == OP_SLL);
        if (state_q == S_WB_AL) begin
          regwre_c = 1'b1;
          dbsrc_c  = 1'b0;
          wrsrc_c  = 1'b1;
          pcwre_c  = 1'b1;
          regdst_c = is_imm_op(Opcode) ? DST_RT : DST_RD;
        end
      end
      S_EXE_BR: begin
        aluop_c = ALU_SUB;
        srcb_c  = 1'b0;
        pcwre_c = 1'b1;
        if (((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BLTZ) && Sign))
          pcsrc_c = PC_BRANCH;
      end
      S_EXE_LS, S_MEM, S_WB_LD: begin
        aluop_c = ALU_ADD;
        srcb_c  = 1'b1;
        ext_c   = EXT_SIMM;
        if (state_q == S_MEM) begin
          if (Opcode == OP_SW) begin
            mwr_c   = 1'b1;
            pcwre_c = 1'b1;
          end else if (Opcode == OP_LW) begin
            mrd_c = 1'b1;
          end
        end
        if (state_q == S_WB_LD) begin
          mrd_c    = 1'b1;
          dbsrc_c  = 1'b1;
          regwre_c = 1'b1;
          regdst_c = DST_RT;
          wrsrc_c  = 1'b1;
          pcwre_c  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Write strobes are qualified by reset so nothing commits while it is low.
  assign PCWre     = pcwre_c  & RST_n;
  assign IRWre     = irwre_c  & RST_n;
  assign RegWre    = regwre_c & RST_n;
  assign mWR       = mwr_c    & RST_n;
  assign mRD       = mrd_c    & RST_n;
  assign InsMemRW  = insmem_c;
  assign ALUSrcA   = srca_c;
  assign ALUSrcB   = srcb_c;
  assign ALUOp     = aluop_c;
  assign ExtSel    = RST_n ? ext_c : EXT_SIMM;
  assign RegDst    = regdst_c;
  assign WrRegDSrc = wrsrc_c;
  assign DBDataSrc = dbsrc_c;
  assign PCSrc     = pcsrc_c;
  assign State     = state_q;

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle MIPS control FSM. Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath strobe and mux select, including ExtSel into the immediate extend stage.
- Consumes the opcode held in the instruction register, plus the ALU Zero and Sign flags.
- Sits between the IR and the whole datapath.

Parameters:
- OPW, 6, opcode width.
- STW, 4, state register width.

Ports:
- CLK  in  1  rising-edge clock
- RST_n  in  1  asynchronous active-low reset
- Opcode  in  6  IR[31:26], stable from ID to end of instruction
- Zero  in  1  ALU result == 0
- Sign  in  1  ALU result[31]
- PCWre  out  1  PC load strobe
- IRWre  out  1  IR load strobe
- InsMemRW  out  1  instruction memory read enable
- ALUSrcA  out  1  0 = rs, 1 = extended shamt
- ALUSrcB  out  1  0 = rt, 1 = extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 sll, 101 slt signed, 110 sltu, 111 xor
- ExtSel  out  2  00 zero-ext shamt field, 01 zero-ext imm16, 10 sign-ext imm16
- RegWre  out  1  register file write enable
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  0 = PC+4, 1 = DB bus
- DBDataSrc  out  1  0 = ALU result, 1 = data memory
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- PCSrc  out  2  00 PC+4, 01 PC+4+(ext<<2), 10 rs, 11 jump target
- State  out  4  current state, for debug and LEDs

Behaviour:
- Single clock CLK; reset RST_n asynchronous, active-low.
- State register is the only storage. Outputs are combinational from (State, Opcode, Zero, Sign).
- All write strobes (PCWre, IRWre, RegWre, mWR) are ANDed with RST_n.
- Reset: State = IF. PCWre = IRWre = RegWre = mWR = mRD = 0. InsMemRW = 1. All selects 0, except ExtSel = 10.
- States: IF=0000, ID=0001, EXE_AL=0010, EXE_BR=0011, EXE_LS=0100, MEM=0101, WB_AL=0110, WB_LD=0111, HALT=1000.
- Opcodes:
  - ALU: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sltiu 100111.
  - Memory: sw 110000, lw 110001.
  - Branch: beq 110100, bltz 110110.
  - Jump: j 111000, jr 111001, jal 111010.
  - halt 111111.
- IF: IRWre = 1, InsMemRW = 1. Next state ID unconditionally.
- ID:
  - j: PCSrc = 11, PCWre = 1, next IF.
  - jr: PCSrc = 10, PCWre = 1, next IF.
  - jal: PCSrc = 11, PCWre = 1, RegWre = 1, RegDst = 00, WrRegDSrc = 0, next IF.
  - halt: next HALT.
  - ALU ops: next EXE_AL. beq/bltz: next EXE_BR. lw/sw: next EXE_LS.
  - Undefined opcode: next HALT.
- EXE_AL: ALU controls per opcode; next WB_AL.
  - ALUOp: add/addi 000, sub 001, or/ori 010, and 011, sll 100, slt 101, sltiu 110.
  - ALUSrcB = 1 for addi, ori, sltiu.
  - ALUSrcA = 1 for sll only.
- EXE_BR: ALUOp = 001, ALUSrcB = 0, PCWre = 1, next IF.
  - PCSrc = 01 if (beq and Zero) or (bltz and Sign), else 00.
  - bltz compares rs against $0 through rt = $0; the control unit does not special-case it.
- EXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 10; next MEM.
- MEM (address inputs held):
  - sw: mWR = 1, PCWre = 1, next IF.
  - lw: mRD = 1, next WB_LD.
- WB_AL: RegWre = 1, DBDataSrc = 0, WrRegDSrc = 1, PCWre = 1, next IF.
  - RegDst = 10 for R-type ops, 01 for immediate ops.
- WB_LD: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, WrRegDSrc = 1, PCWre = 1, next IF.
- HALT: all strobes 0; stays in HALT until RST_n is low.
- ExtSel (every state, per opcode):
  - ori 01; sll 00.
  - addi, sltiu, lw, sw, beq, bltz 10.
  - All others 10.
- Latency in cycles: j/jr/jal 2; beq/bltz 3; ALU ops 4; sw 4; lw 5; halt terminal.
- PCWre is asserted exactly once per instruction, in its final state. IRWre is asserted only in IF.
- Reset asserted mid-instruction: State goes to IF immediately; strobes drop in the same cycle; no partial register or memory write completes.

Decomposition:
- Package mc_defs holds:
  - opcode constants, state encodings;
  - ALUOp, ExtSel, PCSrc and RegDst encodings.
- Natural sub-module: mc_next_state (combinational next-state logic), instantiated beside the output decode in mc_control_unit.

Test Plan:
- RST_n low mid-EXE_AL -> State = 0000 on the same edge; RegWre = PCWre = 0 while low; first cycle after release has IRWre = 1.
- Opcode 000010 (addi) -> State sequence 0,1,2,6,0. In EXE_AL: ALUSrcB = 1, ExtSel = 10, ALUOp = 000. In WB_AL: RegWre = 1, RegDst = 01, PCWre = 1.
- Opcode 110100 (beq), two runs:
  - Zero = 1 -> State 0,1,3,0 with PCSrc = 01 and PCWre = 1 in EXE_BR.
  - Zero = 0 -> PCSrc = 00.
- Opcode 110001 (lw) -> State 0,1,4,5,7,0. mRD = 1 in MEM and WB_LD; DBDataSrc = 1 and RegWre = 1 in WB_LD.
- Opcode 111010 (jal) -> in ID: PCSrc = 11, RegWre = 1, RegDst = 00, WrRegDSrc = 0; next state IF.
- Opcode 111111, then opcode 101010 after reset -> State goes to 1000 and holds for 20 cycles with all strobes 0.
